// File: rtl/processing_element_vec_if.sv
// Control, MAC data and drain-chain signals of one vector processing element.
interface processing_element_vec_if #(
  parameter int unsigned WIDTH_A   = 8,
  parameter int unsigned WIDTH_B   = 8,
  parameter int unsigned WIDTH_ACC = 32,
  parameter int unsigned LANES     = 4
);
  logic                       mode;
  logic                       clear;
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*WIDTH_A-1:0]   act_in;
  logic [LANES*WIDTH_B-1:0]   wei_in;
  logic                       wload;
  logic [LANES*WIDTH_ACC-1:0] psum_in;
  logic [LANES*WIDTH_ACC-1:0] psum_out;
  logic                       psum_valid;
  logic [LANES*WIDTH_A-1:0]   act_out;
  logic [LANES*WIDTH_B-1:0]   wei_out;
  logic                       fwd_valid;
  logic                       drain_start;
  logic [LANES*WIDTH_ACC-1:0] drain_in;
  logic                       drain_in_valid;
  logic                       drain_in_ready;
  logic [LANES*WIDTH_ACC-1:0] drain_out;
  logic                       drain_out_valid;
  logic                       drain_ready;
  logic                       busy;
  logic [LANES-1:0]           ovf;

  modport master (
    output mode, clear, in_valid, act_in, wei_in, wload, psum_in, drain_start, drain_in,
           drain_in_valid, drain_ready,
    input  in_ready, psum_out, psum_valid, act_out, wei_out, fwd_valid, drain_in_ready,
           drain_out, drain_out_valid, busy, ovf
  );

  modport slave (
    input  mode, clear, in_valid, act_in, wei_in, wload, psum_in, drain_start, drain_in,
           drain_in_valid, drain_ready,
    output in_ready, psum_out, psum_valid, act_out, wei_out, fwd_valid, drain_in_ready,
           drain_out, drain_out_valid, busy, ovf
  );
endinterface

// File: rtl/processing_element_vec.sv
// Vector MAC processing element: output-/weight-stationary modes with a daisy-chained drain.
// Define PE_SATURATE_EN for saturating accumulation with sticky per-lane overflow flags.
module processing_element_vec #(
  parameter int unsigned WIDTH_A   = 8,
  parameter int unsigned WIDTH_B   = 8,
  parameter int unsigned WIDTH_ACC = 32,
  parameter int unsigned LANES     = 4,
  parameter int unsigned STAGES    = 1,
  parameter int unsigned SIGNED    = 1,
  parameter int unsigned UPSTREAM  = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  processing_element_vec_if.slave bus
);
  localparam int unsigned PW  = WIDTH_A + WIDTH_B;
  localparam logic        SGN = (SIGNED != 0);
  localparam int unsigned CW  = $clog2(UPSTREAM + 2);
  localparam logic [CW-1:0] LAST = CW'(UPSTREAM > 0 ? UPSTREAM - 1 : 0);
`ifdef PE_SATURATE_EN
  localparam int unsigned MSB = WIDTH_ACC - 1;
  localparam logic [WIDTH_ACC-1:0] SMAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic [WIDTH_ACC-1:0] SMIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};
`endif

  typedef enum logic [1:0] {StRun, StWait, StDrain, StPass} state_e;

  function automatic logic [WIDTH_ACC-1:0] mul_ext(input logic [WIDTH_A-1:0] a,
                                                   input logic [WIDTH_B-1:0] b);
    logic [PW-1:0] xa, xb, p;
    xa = {{WIDTH_B{SGN & a[WIDTH_A-1]}}, a};
    xb = {{WIDTH_A{SGN & b[WIDTH_B-1]}}, b};
    p  = xa * xb;
    if (SGN) return WIDTH_ACC'($signed(p));
    else     return WIDTH_ACC'(p);
  endfunction

  // Returns {overflow, sum}.
  function automatic logic [WIDTH_ACC:0] add_acc(input logic [WIDTH_ACC-1:0] a,
                                                 input logic [WIDTH_ACC-1:0] b);
    logic [WIDTH_ACC-1:0] s;
    logic                 o;
    s = a + b;
    o = 1'b0;
`ifdef PE_SATURATE_EN
    if (SGN) begin
      if ((a[MSB] == b[MSB]) && (s[MSB] != a[MSB])) begin
        o = 1'b1;
        s = a[MSB] ? SMIN : SMAX;
      end
    end else if (s < a) begin
      o = 1'b1;
      s = '1;
    end
`endif
    return {o, s};
  endfunction

  state_e           r_state;
  logic             r_busy, r_in_ready, r_drain_own, r_pass;
  logic [CW-1:0]    r_cnt;

  logic [LANES-1:0][WIDTH_A-1:0]   w_act, r_ma, r_act_out;
  logic [LANES-1:0][WIDTH_B-1:0]   w_wei, w_wsel, r_mb, r_w, r_wei_out;
  logic [LANES-1:0][WIDTH_ACC-1:0] w_psin, w_prod0, w_prod, w_prod_g, w_os_sum, w_ws_sum;
  logic [LANES-1:0][WIDTH_ACC-1:0] r_acc, r_psum_out;
  logic [LANES-1:0]                w_en, w_os_ovf, w_ws_ovf, r_ovf;
  logic                            r_fwd_valid, r_psum_valid;

  logic [STAGES-1:0]                             r_v;
  logic [STAGES-1:0][LANES-1:0]                  r_en;
  logic [STAGES-1:0][LANES-1:0][WIDTH_ACC-1:0]   r_ps;

  logic w_fire, w_wl, w_issue, w_pv;

  assign w_act   = bus.act_in;
  assign w_wei   = bus.wei_in;
  assign w_psin  = bus.psum_in;
  assign w_fire  = bus.in_valid & r_in_ready;
  assign w_wl    = w_fire & bus.mode & bus.wload;
  assign w_issue = w_fire & ~w_wl;
  assign w_pv    = r_v[STAGES-1];

  always_comb begin
    w_wsel  = '0;
    w_en    = '0;
    w_prod0 = '0;
    for (int l = 0; l < LANES; l++) begin
      w_wsel[l]  = bus.mode ? r_w[l] : w_wei[l];
      w_en[l]    = (w_act[l] != '0) && (w_wsel[l] != '0);
      w_prod0[l] = mul_ext(r_ma[l], r_mb[l]);
    end
  end

  // Gated lanes contribute zero, so their accumulator and WS sum pass through unchanged.
  always_comb begin
    w_prod_g = '0;
    w_os_sum = '0;
    w_os_ovf = '0;
    w_ws_sum = '0;
    w_ws_ovf = '0;
    for (int l = 0; l < LANES; l++) begin
      w_prod_g[l] = r_en[STAGES-1][l] ? w_prod[l] : '0;
      {w_os_ovf[l], w_os_sum[l]} = add_acc(r_acc[l], w_prod_g[l]);
      {w_ws_ovf[l], w_ws_sum[l]} = add_acc(r_ps[STAGES-1][l], w_prod_g[l]);
    end
  end

  if (STAGES == 1) begin : g_one
    assign w_prod = w_prod0;
  end else begin : g_pipe
    logic [STAGES-2:0][LANES-1:0][WIDTH_ACC-1:0] r_p;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_p <= '0;
      end else if (bus.clear) begin
        r_p <= '0;
      end else begin
        r_p[0] <= w_prod0;
        for (int s = 1; s < STAGES - 1; s++) r_p[s] <= r_p[s-1];
      end
    end
    assign w_prod = r_p[STAGES-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_out <= '0; r_wei_out <= '0; r_fwd_valid <= 1'b0; r_w <= '0;
      r_ma <= '0; r_mb <= '0; r_v <= '0; r_en <= '0; r_ps <= '0;
      r_acc <= '0; r_psum_out <= '0; r_psum_valid <= 1'b0; r_ovf <= '0;
    end else if (bus.clear) begin
      r_act_out <= '0; r_wei_out <= '0; r_fwd_valid <= 1'b0; r_w <= '0;
      r_ma <= '0; r_mb <= '0; r_v <= '0; r_en <= '0; r_ps <= '0;
      r_acc <= '0; r_psum_out <= '0; r_psum_valid <= 1'b0; r_ovf <= '0;
    end else begin
      r_fwd_valid <= w_fire;
      if (w_fire) begin
        r_act_out <= w_act;
        r_wei_out <= w_wei;
      end
      if (w_wl) r_w <= w_wei;
      for (int l = 0; l < LANES; l++) begin
        if (w_issue && w_en[l]) begin
          r_ma[l] <= w_act[l];
          r_mb[l] <= w_wsel[l];
        end
      end
      r_v[0]  <= w_issue;
      r_en[0] <= w_issue ? w_en : '0;
      if (w_issue) r_ps[0] <= w_psin;
      for (int s = 1; s < STAGES; s++) begin
        r_v[s]  <= r_v[s-1];
        r_en[s] <= r_en[s-1];
        r_ps[s] <= r_ps[s-1];
      end
      r_psum_valid <= w_pv & bus.mode;
      if (w_pv & bus.mode) begin
        r_psum_out <= w_ws_sum;
        r_ovf      <= r_ovf | w_ws_ovf;
      end
      if (r_drain_own & bus.drain_ready) begin
        r_acc <= '0;
      end else if (w_pv & ~bus.mode) begin
        r_acc <= w_os_sum;
        r_ovf <= r_ovf | w_os_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun; r_busy <= 1'b0; r_in_ready <= 1'b1;
      r_drain_own <= 1'b0; r_pass <= 1'b0; r_cnt <= '0;
    end else if (bus.clear) begin
      r_state <= StRun; r_busy <= 1'b0; r_in_ready <= 1'b1;
      r_drain_own <= 1'b0; r_pass <= 1'b0; r_cnt <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (bus.drain_start && !bus.mode) begin
            r_state    <= StWait;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
          end
        end
        StWait: begin
          if (r_v == '0) begin
            r_state     <= StDrain;
            r_drain_own <= 1'b1;
          end
        end
        StDrain: begin
          if (bus.drain_ready) begin
            r_drain_own <= 1'b0;
            r_cnt       <= '0;
            if (UPSTREAM > 0) begin
              r_state <= StPass;
              r_pass  <= 1'b1;
            end else begin
              r_state    <= StRun;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end
        end
        StPass: begin
          if (bus.drain_in_valid && bus.drain_ready) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_state    <= StRun;
              r_pass     <= 1'b0;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.busy            = r_busy;
  assign bus.act_out         = r_act_out;
  assign bus.wei_out         = r_wei_out;
  assign bus.fwd_valid       = r_fwd_valid;
  assign bus.psum_out        = r_psum_out;
  assign bus.psum_valid      = r_psum_valid;
  assign bus.ovf             = r_ovf;
  assign bus.drain_out       = r_pass ? bus.drain_in : (r_drain_own ? r_acc : '0);
  assign bus.drain_out_valid = r_pass ? bus.drain_in_valid : r_drain_own;
  assign bus.drain_in_ready  = r_pass & bus.drain_ready;
endmodule
